// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shared-shifter request arbiter.
// Optional rotate support is selected by the SHIFT_ROTATE_EN macro in the top.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    RESP   = 2'd2,
    SHIFT2 = 2'd3
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SHW   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping at NREQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            any_o
);

  int   idx;
  logic found;

  // Scan NREQ slots starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = |req_i;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_i) + i) % NREQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/shift_req_arbiter.sv
// Shares one barrel shifter between NREQ requesters. Round-robin grant,
// one cycle for the shifter to settle, then a held valid/ready response.
// Define SHIFT_ROTATE_EN to add req_rot and a second pass that builds a rotate.
module shift_req_arbiter
  import shift_ctrl_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_dir,
  input  logic [NREQ*SHW-1:0]   req_amt,
`ifdef SHIFT_ROTATE_EN
  input  logic [NREQ-1:0]       req_rot,
`endif
  output logic [WIDTH-1:0]      shf_i,
  output logic                  shf_dir,
  output logic [SHW-1:0]        shf_amt,
  input  logic [WIDTH-1:0]      shf_o0,
  input  logic [WIDTH-1:0]      shf_o1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             dir_q, dir_d;
  logic [SHW-1:0]   amt_q, amt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
`ifdef SHIFT_ROTATE_EN
  logic             rot_q, rot_d;
  logic [WIDTH-1:0] pass1_q, pass1_d;
`endif

  logic [NREQ-1:0]  gnt_oh;
  logic [IDW-1:0]   gnt_idx;
  logic             any_req;
  logic [WIDTH-1:0] shifted;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_req)
  );

  // Shifter result for the direction currently driven.
  assign shifted = (dir_q == DIR_RIGHT) ? shf_o1 : shf_o0;

  assign shf_i     = opnd_q;
  assign shf_dir   = dir_q;
  assign shf_amt   = amt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

  // Next-state and ready logic; ready is gated by rst so it drops at once.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    opnd_d      = opnd_q;
    dir_d       = dir_q;
    amt_d       = amt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
`ifdef SHIFT_ROTATE_EN
    rot_d       = rot_q;
    pass1_d     = pass1_q;
`endif
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (any_req && !rst) begin
          req_ready = gnt_oh;
          opnd_d    = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
          dir_d     = req_dir[gnt_idx];
          amt_d     = req_amt[int'(gnt_idx)*SHW +: SHW];
          rsp_id_d  = gnt_idx;
`ifdef SHIFT_ROTATE_EN
          rot_d     = req_rot[gnt_idx];
`endif
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
`ifdef SHIFT_ROTATE_EN
        if (rot_q && (amt_q != '0)) begin
          // Second pass in the opposite direction fills the wrapped bits.
          pass1_d = shifted;
          dir_d   = ~dir_q;
          amt_d   = SHW'(WIDTH) - amt_q;
          state_d = SHIFT2;
        end else begin
          rsp_data_d  = shifted;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`else
        rsp_data_d  = shifted;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
`endif
      end
`ifdef SHIFT_ROTATE_EN
      SHIFT2: begin
        rsp_data_d  = pass1_q | shifted;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (rsp_id_q == IDW'(NREQ-1)) ? '0 : rsp_id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      opnd_q      <= '0;
      dir_q       <= 1'b0;
      amt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
`ifdef SHIFT_ROTATE_EN
      rot_q       <= 1'b0;
      pass1_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      opnd_q      <= opnd_d;
      dir_q       <= dir_d;
      amt_q       <= amt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
`ifdef SHIFT_ROTATE_EN
      rot_q       <= rot_d;
      pass1_q     <= pass1_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Directed bench for shift_req_arbiter with a behavioural shifter and a
// response scoreboard. Rotate cases are included when SHIFT_ROTATE_EN is set.
module tb_shift_req_arbiter;

  localparam int NREQ = 2, WIDTH = 16, SHW = 4, IDW = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_ready, req_dir, req_rot;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ*SHW-1:0]   req_amt;
  logic [WIDTH-1:0]      shf_i, shf_o0, shf_o1, rsp_data;
  logic                  shf_dir, rsp_valid, rsp_ready;
  logic [SHW-1:0]        shf_amt;
  logic [IDW-1:0]        rsp_id;

  typedef struct { logic [WIDTH-1:0] d; int id; } exp_t;
  exp_t exp_q[$];
  exp_t last_exp;

  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shifter the block drives.
  assign shf_o0 = shf_i << shf_amt;
  assign shf_o1 = shf_i >> shf_amt;

  shift_req_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SHW(SHW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_dir(req_dir), .req_amt(req_amt),
`ifdef SHIFT_ROTATE_EN
    .req_rot(req_rot),
`endif
    .shf_i(shf_i), .shf_dir(shf_dir), .shf_amt(shf_amt),
    .shf_o0(shf_o0), .shf_o1(shf_o1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  function automatic logic [WIDTH-1:0] model(logic [WIDTH-1:0] d, logic dr,
                                             logic [SHW-1:0] a, logic rt);
    if (rt && a != 0)
      return dr ? ((d >> a) | (d << (16 - a))) : ((d << a) | (d >> (16 - a)));
    return dr ? (d >> a) : (d << a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int k, input logic [WIDTH-1:0] d, input logic dr,
                       input logic [SHW-1:0] a, input logic rt);
    req_data[k*WIDTH +: WIDTH] = d;
    req_dir[k]                 = dr;
    req_amt[k*SHW +: SHW]      = a;
    req_rot[k]                 = rt;
    req_valid[k]               = 1'b1;
  endtask

  // Call at a negedge; returns granted index (-1 on timeout) and accept cycle.
  task automatic wait_accept(output int g, output int c);
    g = -1; c = 0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (req_ready != '0) begin
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
        c = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("accept_seen", 32'(g >= 0), 32'd1);
    if (g >= 0) chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
  endtask

  // Count negedges until rsp_valid, then pop the scoreboard and compare.
  task automatic wait_rsp(input int lat_exp);
    int lat;
    lat = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    chk("rsp_latency", 32'(lat), 32'(lat_exp));
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      last_exp = exp_q.pop_front();
      chk("rsp_data", 32'(rsp_data), 32'(last_exp.d));
      chk("rsp_id", 32'(rsp_id), 32'(last_exp.id));
    end
  endtask

  // One full transaction from requester k (already issued); returns accept cycle.
  task automatic op(input int k, input logic [WIDTH-1:0] d, input logic dr,
                    input logic [SHW-1:0] a, input logic rt, input int lat_exp,
                    input logic drop, output int c);
    int g;
    wait_accept(g, c);
    chk("grant_id", 32'(g), 32'(k));
    exp_q.push_back('{d: model(d, dr, a, rt), id: k});
    @(posedge clk); #1;
    if (drop) req_valid[k] = 1'b0;
    wait_rsp(lat_exp);
  endtask

  initial begin
    int c, prev, g;
    rst = 1'b1; req_valid = '0; req_dir = '0; req_rot = '0;
    req_data = '0; req_amt = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_shf_i", 32'(shf_i), 0);
    chk("rst_shf_dir", 32'(shf_dir), 0);
    chk("rst_shf_amt", 32'(shf_amt), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 0);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);

    // Basic shifts and boundary amounts.
    rsp_ready = 1'b1;
    issue(0, 16'h00F1, 1'b0, 4'd4, 1'b0);
    op(0, 16'h00F1, 1'b0, 4'd4, 1'b0, 2, 1'b1, c);
    @(negedge clk);
    issue(1, 16'h8000, 1'b1, 4'd15, 1'b0);
    op(1, 16'h8000, 1'b1, 4'd15, 1'b0, 2, 1'b1, c);
    @(negedge clk);
    issue(0, 16'hFFFF, 1'b0, 4'd15, 1'b0);
    op(0, 16'hFFFF, 1'b0, 4'd15, 1'b0, 2, 1'b1, c);
    @(negedge clk);
    issue(1, 16'hA5A5, 1'b1, 4'd0, 1'b0);
    op(1, 16'hA5A5, 1'b1, 4'd0, 1'b0, 2, 1'b1, c);
    @(negedge clk);

    // Fairness: both valid continuously, grants alternate 3 cycles apart.
    issue(0, 16'h1234, 1'b0, 4'd1, 1'b0);
    issue(1, 16'h1234, 1'b1, 4'd2, 1'b0);
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) op(0, 16'h1234, 1'b0, 4'd1, 1'b0, 2, 1'b0, c);
      else            op(1, 16'h1234, 1'b1, 4'd2, 1'b0, 2, 1'b0, c);
      if (i > 0) chk("accept_spacing", 32'(c - prev), 32'd3);
      prev = c;
    end
    req_valid = '0;
    @(negedge clk);

    // Response stall: outputs hold, nothing else accepted.
    rsp_ready = 1'b0;
    issue(0, 16'h0F0F, 1'b1, 4'd4, 1'b0);
    issue(1, 16'h1111, 1'b0, 4'd1, 1'b0);
    wait_accept(g, c);
    chk("stall_grant", 32'(g), 0);
    exp_q.push_back('{d: model(16'h0F0F, 1'b1, 4'd4, 1'b0), id: 0});
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_data", 32'(rsp_data), 32'(last_exp.d));
      chk("stall_id", 32'(rsp_id), 32'(last_exp.id));
      chk("stall_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 32'(rsp_valid), 0);
    op(1, 16'h1111, 1'b0, 4'd1, 1'b0, 2, 1'b1, c);
    @(negedge clk);

    // Move the pointer to 1, then reset during SHIFT of requester 1.
    issue(0, 16'h0003, 1'b0, 4'd2, 1'b0);
    op(0, 16'h0003, 1'b0, 4'd2, 1'b0, 2, 1'b1, c);
    @(negedge clk);
    issue(0, 16'h00FF, 1'b0, 4'd0, 1'b0);
    issue(1, 16'h00FF, 1'b1, 4'd3, 1'b0);
    wait_accept(g, c);
    chk("pre_rst_grant", 32'(g), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    op(0, 16'h00FF, 1'b0, 4'd0, 1'b0, 2, 1'b1, c);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("dropped_not_served", 32'(rsp_valid), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);

`ifdef SHIFT_ROTATE_EN
    issue(0, 16'h8001, 1'b0, 4'd1, 1'b1);
    op(0, 16'h8001, 1'b0, 4'd1, 1'b1, 3, 1'b1, c);
    @(negedge clk);
    issue(1, 16'h1234, 1'b1, 4'd4, 1'b1);
    op(1, 16'h1234, 1'b1, 4'd4, 1'b1, 3, 1'b1, c);
    @(negedge clk);
    issue(0, 16'h1234, 1'b1, 4'd0, 1'b1);
    op(0, 16'h1234, 1'b1, 4'd0, 1'b1, 2, 1'b1, c);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_req_arbiter.md
Name: shift_req_arbiter

Overview:
- Shares one 16-bit left/right barrel shifter datapath between NREQ requesters.
- Each requester issues an operand, a direction and a shift amount over a valid/ready handshake.
- The block picks one request by round-robin, drives the shifter, captures the result and returns it with the requester ID over a valid/ready response channel.
- Sits between client blocks (ALU sequencer, test driver) and the shifter instance.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 16, data width; must match the shifter.
- SHW, 4, shift-amount width, log2(WIDTH).
- IDW, 1, requester ID width, clog2(NREQ) with a minimum of 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_data  in  NREQ*WIDTH  operands; requester k uses slice [k*WIDTH +: WIDTH].
- req_dir  in  NREQ  0 = left, 1 = right (logical).
- req_amt  in  NREQ*SHW  shift amounts; requester k uses slice [k*SHW +: SHW].
- shf_i  out  WIDTH  operand to shifter.
- shf_dir  out  1  shifter direction select.
- shf_amt  out  SHW  shifter stage selects; bit b enables the 2^b stage.
- shf_o0  in  WIDTH  shifter left result.
- shf_o1  in  WIDTH  shifter right result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  WIDTH  shifted result.
- rsp_id  out  IDW  index of the requester served.

Behaviour:
- Reset (async assert, sync deassert by the user): state = IDLE, rr_ptr = 0, and shf_i, shf_dir, shf_amt, rsp_valid, rsp_data, rsp_id and req_ready all 0.
- FSM states: IDLE, SHIFT, RESP.
- IDLE
  - If no req_valid is set: stay in IDLE with req_ready = 0.
  - Otherwise grant g = the first k with req_valid[k] set, searching from rr_ptr upward and wrapping at NREQ.
  - req_ready[g] = 1 combinationally in the same cycle; the handshake completes on that edge.
  - On that edge: register shf_i, shf_dir and shf_amt from slice g, set rsp_id = g, go to SHIFT.
- SHIFT (one cycle, shifter settles)
  - Capture rsp_data = shf_dir ? shf_o1 : shf_o0.
  - Set rsp_valid = 1 and go to RESP.
- RESP
  - Hold rsp_valid, rsp_data and rsp_id stable until rsp_ready = 1.
  - On that edge: rsp_valid = 0, rr_ptr = (g+1) mod NREQ, go to IDLE.
  - req_ready = 0 for all requesters throughout RESP.
- Latency and throughput:
  - Request accepted at edge T; rsp_valid high after edge T+2.
  - Minimum spacing of 3 cycles per operation with rsp_ready tied high.
- Shifter inputs hold their last values outside SHIFT; no glitch requirement.
- Boundary conditions:
  - amt = 0: result equals the operand.
  - amt = 15: only one bit survives.
  - Shifts are logical with zero fill; there is no wrap.
  - Only the granted requester sees ready; the others keep valid and their data stable (requester obligation).
  - A requester that drops valid before being granted is not served; there is no error.
  - rsp_ready held low indefinitely: the block stalls in RESP and accepts nothing.
  - rsp_ready high while rsp_valid is low is ignored.
  - rst mid-operation: the in-flight request is discarded; rsp_valid and req_ready go low immediately.
- Fairness: with all requesters valid continuously, grants rotate 0, 1, ..., NREQ-1, 0, ...

Optional Feature:
- SHIFT_ROTATE_EN
  - Defined:
    - Adds port req_rot in NREQ.
    - When the granted req_rot = 1 and amt != 0, a second pass state SHIFT2 follows SHIFT.
    - Pass 1 uses dir/amt; its result is held in an internal register.
    - Pass 2 uses the opposite dir with amount WIDTH-amt (mod 2^SHW).
    - rsp_data = pass1 | pass2, giving a rotate; latency becomes T+3.
    - rot with amt = 0 is a single pass and returns the operand.
  - Undefined: no req_rot port, no SHIFT2 state, logical shifts only.

Decomposition:
- Package shift_ctrl_pkg holds:
  - FSM state enum (IDLE, SHIFT, RESP, SHIFT2).
  - DIR_LEFT = 0 and DIR_RIGHT = 1.
  - Default WIDTH = 16 and SHW = 4.
- Sub-module rr_arbiter (NREQ):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, binary grant index, any_req.
  - Purely combinational; rr_ptr stays in the parent.

Test Plan:
- Reset release, idle: all outputs 0. Then req0 data=16'h00F1, dir=0, amt=4 -> rsp_valid 2 cycles after accept; rsp_data=16'h0F10, rsp_id=0.
- req1 data=16'h8000, dir=1, amt=15 -> rsp_data=16'h0001, rsp_id=1. Then amt=0 with data=16'hA5A5 -> rsp_data=16'hA5A5.
- Both valid continuously for 6 operations, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1; each accept exactly 3 cycles apart.
- rsp_ready low for 5 cycles in RESP -> rsp_valid/data/id stable; req_ready stays 0 throughout; completes on the first high rsp_ready.
- rst pulsed during SHIFT -> rsp_valid stays 0 and state returns to IDLE. The next request is served normally, with grant starting from requester 0.
- (SHIFT_ROTATE_EN) data=16'h8001, dir=0, amt=1, rot=1 -> rsp_data=16'h0003, latency 3 cycles. rot=1 with amt=0 -> operand returned at latency 2.
